// File: rtl/cpu_synth_cfg_ctrl.sv
// rtl/cpu_synth_cfg_ctrl.sv - MMIO shadow registers and four-phase snapshot handshake toward the synth CDC
//
// Purpose: the CPU writes synth configuration into shadow registers. A commit
// (or, with SYNTH_CFG_AUTOSEND_EN defined, any register write) marks the shadow
// set pending. The FSM then copies every shadow register into the held outputs
// in one edge and runs a four-phase req/ack handshake so the CDC can sample a
// coherent set.
//
// Build option: SYNTH_CFG_AUTOSEND_EN - when defined, every accepted write to
// 0x00..0x13 also sets pending; otherwise only a write to 0x14 does.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  single-cycle MMIO write
//   rd_addr/rd_data     MMIO read, rd_data registered one cycle after rd_addr
//   cpu_carrier_fcws, cpu_mod_fcw, cpu_mod_shift, cpu_note_en, cpu_synth_shift
//                       held configuration, stable while a handshake runs
//   cpu_req/cpu_ack     four-phase handshake (cpu_ack already synchronised)
//   busy                high whenever the FSM is not idle
module cpu_synth_cfg_ctrl #(
    parameter int N_VOICES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [4:0]               wr_addr,
    input  logic [23:0]              wr_data,
    input  logic [4:0]               rd_addr,
    output logic [23:0]              rd_data,
    output logic [N_VOICES-1:0][23:0] cpu_carrier_fcws,
    output logic [23:0]              cpu_mod_fcw,
    output logic [4:0]               cpu_mod_shift,
    output logic [N_VOICES-1:0]      cpu_note_en,
    output logic [4:0]               cpu_synth_shift,
    output logic                     cpu_req,
    input  logic                     cpu_ack,
    output logic                     busy
);

    localparam logic [4:0] ADDR_MOD_FCW     = 5'h10;
    localparam logic [4:0] ADDR_MOD_SHIFT   = 5'h11;
    localparam logic [4:0] ADDR_NOTE_EN     = 5'h12;
    localparam logic [4:0] ADDR_SYNTH_SHIFT = 5'h13;
    localparam logic [4:0] ADDR_COMMIT      = 5'h14;
    localparam logic [4:0] ADDR_STATUS      = 5'h15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_HI = 2'd1,
        S_ACK_LO = 2'd2
    } state_e;

    state_e state_q, state_d;

    // shadow registers (CPU-visible)
    logic [N_VOICES-1:0][23:0] sh_car_q, sh_car_d;
    logic [23:0]               sh_mod_fcw_q, sh_mod_fcw_d;
    logic [4:0]                sh_mod_shift_q, sh_mod_shift_d;
    logic [N_VOICES-1:0]       sh_note_en_q, sh_note_en_d;
    logic [4:0]                sh_synth_shift_q, sh_synth_shift_d;

    // held registers (CDC-visible)
    logic [N_VOICES-1:0][23:0] hd_car_q, hd_car_d;
    logic [23:0]               hd_mod_fcw_q, hd_mod_fcw_d;
    logic [4:0]                hd_mod_shift_q, hd_mod_shift_d;
    logic [N_VOICES-1:0]       hd_note_en_q, hd_note_en_d;
    logic [4:0]                hd_synth_shift_q, hd_synth_shift_d;

    logic        pending_q, pending_d;
    logic        cpu_req_q, cpu_req_d;
    logic        busy_q, busy_d;
    logic [23:0] rd_data_q, rd_data_d;

    logic wr_carrier, wr_reg_hit, wr_commit, trigger, snapshot;

    // write decode
    always_comb begin
        wr_carrier = wr_en && !wr_addr[4] && (int'(wr_addr[3:0]) < N_VOICES);
        wr_reg_hit = wr_en && (wr_addr >= ADDR_MOD_FCW) && (wr_addr <= ADDR_SYNTH_SHIFT);
        wr_commit  = wr_en && (wr_addr == ADDR_COMMIT);
`ifdef SYNTH_CFG_AUTOSEND_EN
        trigger    = wr_carrier || wr_reg_hit || wr_commit;
`else
        trigger    = wr_commit;
`endif
    end

    // shadow register updates; narrower fields keep the low bits of wr_data
    always_comb begin
        sh_car_d         = sh_car_q;
        sh_mod_fcw_d     = sh_mod_fcw_q;
        sh_mod_shift_d   = sh_mod_shift_q;
        sh_note_en_d     = sh_note_en_q;
        sh_synth_shift_d = sh_synth_shift_q;
        for (int i = 0; i < N_VOICES; i++) begin
            if (wr_carrier && (int'(wr_addr[3:0]) == i)) begin
                sh_car_d[i] = wr_data;
            end
        end
        if (wr_reg_hit) begin
            case (wr_addr)
                ADDR_MOD_FCW:   sh_mod_fcw_d   = wr_data;
                ADDR_MOD_SHIFT: sh_mod_shift_d = wr_data[4:0];
                ADDR_NOTE_EN:   sh_note_en_d   = wr_data[N_VOICES-1:0];
                default:        sh_synth_shift_d = wr_data[4:0];
            endcase
        end
    end

    // handshake FSM next state; snapshot fires on the IDLE -> REQ_HI edge
    always_comb begin
        state_d  = state_q;
        snapshot = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q && !cpu_ack) begin
                    state_d  = S_REQ_HI;
                    snapshot = 1'b1;
                end
            end
            S_REQ_HI: begin
                if (cpu_ack) begin
                    state_d = S_ACK_LO;
                end
            end
            S_ACK_LO: begin
                if (!cpu_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a trigger coinciding with the snapshot leaves pending set
        pending_d = (pending_q && !snapshot) || trigger;
        cpu_req_d = (state_d == S_REQ_HI);
        busy_d    = (state_d != S_IDLE);
    end

    // held copies take the pre-write shadow values
    always_comb begin
        hd_car_d         = hd_car_q;
        hd_mod_fcw_d     = hd_mod_fcw_q;
        hd_mod_shift_d   = hd_mod_shift_q;
        hd_note_en_d     = hd_note_en_q;
        hd_synth_shift_d = hd_synth_shift_q;
        if (snapshot) begin
            hd_car_d         = sh_car_q;
            hd_mod_fcw_d     = sh_mod_fcw_q;
            hd_mod_shift_d   = sh_mod_shift_q;
            hd_note_en_d     = sh_note_en_q;
            hd_synth_shift_d = sh_synth_shift_q;
        end
    end

    // read mux
    always_comb begin
        rd_data_d = 24'h0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (int'(rd_addr) == i) begin
                rd_data_d = sh_car_q[i];
            end
        end
        case (rd_addr)
            ADDR_MOD_FCW:     rd_data_d = sh_mod_fcw_q;
            ADDR_MOD_SHIFT:   rd_data_d = {19'h0, sh_mod_shift_q};
            ADDR_NOTE_EN:     rd_data_d = {{(24-N_VOICES){1'b0}}, sh_note_en_q};
            ADDR_SYNTH_SHIFT: rd_data_d = {19'h0, sh_synth_shift_q};
            ADDR_STATUS:      rd_data_d = {22'h0, pending_q, busy_q};
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            sh_car_q         <= '0;
            sh_mod_fcw_q     <= '0;
            sh_mod_shift_q   <= '0;
            sh_note_en_q     <= '0;
            sh_synth_shift_q <= '0;
            hd_car_q         <= '0;
            hd_mod_fcw_q     <= '0;
            hd_mod_shift_q   <= '0;
            hd_note_en_q     <= '0;
            hd_synth_shift_q <= '0;
            pending_q        <= 1'b0;
            cpu_req_q        <= 1'b0;
            busy_q           <= 1'b0;
            rd_data_q        <= '0;
        end else begin
            state_q          <= state_d;
            sh_car_q         <= sh_car_d;
            sh_mod_fcw_q     <= sh_mod_fcw_d;
            sh_mod_shift_q   <= sh_mod_shift_d;
            sh_note_en_q     <= sh_note_en_d;
            sh_synth_shift_q <= sh_synth_shift_d;
            hd_car_q         <= hd_car_d;
            hd_mod_fcw_q     <= hd_mod_fcw_d;
            hd_mod_shift_q   <= hd_mod_shift_d;
            hd_note_en_q     <= hd_note_en_d;
            hd_synth_shift_q <= hd_synth_shift_d;
            pending_q        <= pending_d;
            cpu_req_q        <= cpu_req_d;
            busy_q           <= busy_d;
            rd_data_q        <= rd_data_d;
        end
    end

    assign rd_data          = rd_data_q;
    assign cpu_carrier_fcws = hd_car_q;
    assign cpu_mod_fcw      = hd_mod_fcw_q;
    assign cpu_mod_shift    = hd_mod_shift_q;
    assign cpu_note_en      = hd_note_en_q;
    assign cpu_synth_shift  = hd_synth_shift_q;
    assign cpu_req          = cpu_req_q;
    assign busy             = busy_q;

endmodule

// File: doc/cpu_synth_cfg_ctrl.md
CPU_SYNTH_CFG_CTRL -- requirements
Module: cpu_synth_cfg_ctrl

Interface
REQ-001 Parameter N_VOICES, default 1, number of carrier voices (1..16).
REQ-002 clk  input  1  single clock (CPU domain); all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_en  input  1  MMIO write strobe, one cycle per write.
REQ-005 wr_addr  input  5  register select for write.
REQ-006 wr_data  input  24  write data; narrower registers take the low bits.
REQ-007 rd_addr  input  5  register select for read.
REQ-008 rd_data  output  24  read data, registered, valid one cycle after rd_addr.
REQ-009 cpu_carrier_fcws  output  N_VOICES x 24  held carrier FCWs to the CDC.
REQ-010 cpu_mod_fcw  output  24  held modulator FCW.
REQ-011 cpu_mod_shift  output  5  held modulator shift.
REQ-012 cpu_note_en  output  N_VOICES  held per-voice note enables.
REQ-013 cpu_synth_shift  output  5  held output shift.
REQ-014 cpu_req  output  1  four-phase request to the CDC.
REQ-015 cpu_ack  input  1  four-phase acknowledge from the CDC (already synchronised to clk).
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Address map: 0x00..N_VOICES-1 carrier FCW voice i; 0x10 mod_fcw; 0x11 mod_shift; 0x12 note_en; 0x13 synth_shift; 0x14 commit (write-only, data ignored); 0x15 status (read: bit0 busy, bit1 pending).
REQ-018 Writes go to shadow registers; held outputs change only at snapshot.
REQ-019 Writes to unmapped addresses, or to carrier index >= N_VOICES, are ignored and do not set pending.
REQ-020 Reads return shadow values zero-extended to 24 bits; unmapped or write-only addresses read 0.
REQ-021 The pending flag is set by the trigger event (see REQ-031/032) and cleared at snapshot; if a trigger and a snapshot occur in the same cycle, pending ends set.
REQ-022 FSM states: IDLE, REQ_HI, ACK_LO.
REQ-023 IDLE -> REQ_HI when pending=1 and cpu_ack=0: copy all shadow registers to the held outputs on the same edge and assert cpu_req on the next cycle.
REQ-024 REQ_HI: cpu_req=1; go to ACK_LO on the first cycle in which cpu_ack=1.
REQ-025 ACK_LO: cpu_req=0; go to IDLE on the first cycle in which cpu_ack=0.
REQ-026 Held outputs stay constant for the whole of REQ_HI and ACK_LO.
REQ-027 The snapshot captures shadow values as registered before any write in the same cycle; that write sets pending, which causes a further transfer.
REQ-028 Writes are accepted in every state and never stall.
REQ-029 Back-to-back transfers: when pending is set again, IDLE -> REQ_HI follows immediately on returning to IDLE; minimum one IDLE cycle between transfers.
REQ-030 Arithmetic: none; widths are truncated on write, never saturated.

Configuration
REQ-031 With SYNTH_CFG_AUTOSEND_EN defined, every accepted write to 0x00..0x13 sets pending, and a write to 0x14 also sets pending.
REQ-032 Without SYNTH_CFG_AUTOSEND_EN, only a write to 0x14 sets pending; register writes update the shadow registers only.

Reset
REQ-033 On rst: FSM=IDLE; cpu_req=0; busy=0; pending=0; rd_data=0; all shadow and held registers are 0.
REQ-034 Reset mid-handshake drops cpu_req the next cycle; the first post-reset transfer waits in IDLE until cpu_ack=0 (REQ-023).
REQ-035 rst has priority over wr_en in the same cycle.

Verification
REQ-036 Autosend on: write 0x000100 to 0x00 -> held carrier[0]=0x000100 one cycle after the write; cpu_req rises next cycle; with ack looped back through 2 flops, one complete req/ack cycle occurs, then busy=0.
REQ-037 Autosend off: write 0x10=0x0ABCDE, no commit -> cpu_req stays 0 and held mod_fcw=0; write 0x14 -> transfer occurs with held mod_fcw=0x0ABCDE.
REQ-038 Write 0x11=3 while in REQ_HI -> held mod_shift keeps its old value until ACK_LO completes; then a second transfer delivers 3.
REQ-039 Hold cpu_ack=1 externally, pulse rst, then commit -> cpu_req stays 0 until ack is released, then asserts.
REQ-040 N_VOICES=2: write 0x05=0xFFFFFF -> ignored, no pending, rd 0x05 returns 0; write 0x12=0x3 -> rd 0x12 returns 0x000003 and rd 0x15 bit1=1 before the snapshot.
REQ-041 Throughout all scenarios, assertion check: held outputs never change while cpu_req=1 or the state is ACK_LO.
